sequential_shifter: RTL and testbench

SEQUENTIAL_SHIFTER -- requirements
Module: sequential_shifter

---
 rtl/shifter_pkg.sv | 17 +
 rtl/sequential_shifter_shift_step.sv | 29 ++
 rtl/sequential_shifter.sv | 84 ++++++++
 tb/tb_sequential_shifter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter: operation modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/sequential_shifter_shift_step.sv
// One-position shift/rotate of a WIDTH-bit word, plus the bit that leaves it.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    q       = d;
    out_bit = d[0];
    case (mode)
      SLL: begin
        q       = {d[WIDTH-2:0], 1'b0};
        out_bit = d[WIDTH-1];
      end
      SRL:     q = {1'b0, d[WIDTH-1:1]};
      SRA:     q = {d[WIDTH-1], d[WIDTH-1:1]};
      ROR:     q = {d[0], d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/sequential_shifter.sv
// Multi-cycle shifter: one bit position per clock, with busy/done handshake.
module sequential_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shift,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_q),
    .d       (y),
    .q       (step_q),
    .out_bit (step_out)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (shift == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Operands are captured only on acceptance; later input changes never reach the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      y      <= '0;
      carry  <= 1'b0;
      cnt_q  <= '0;
      mode_q <= SLL;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            y      <= a;
            carry  <= 1'b0;
            cnt_q  <= shift;
            mode_q <= mode_e'(mode);
          end
        end
        SHIFT: begin
          y     <= step_q;
          carry <= step_out;
          cnt_q <= cnt_q - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  assign zero = (y == '0);

endmodule

// File: tb/tb_sequential_shifter.sv
// Scoreboard bench for sequential_shifter (WIDTH=4) with hand-computed vectors.
module tb_sequential_shifter;
  import shifter_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] a;
  logic [1:0] shift;
  logic [3:0] y;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  sequential_shifter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .a     (a),
    .shift (shift),
    .y     (y),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [3:0] y;
    logic       c;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   issued    = 0;
  int   done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("y", y, e.y);
          check("carry", carry, e.c);
          check("zero", zero, e.z);
          check("done_cycle", cyc, e.cyc);
          check("busy_in_done", busy, 0);
        end
      end
    end
  endtask

  task automatic expect_result(input logic [3:0] ey, input logic ec, input logic [1:0] sh);
    exp_t e;
    e.y   = ey;
    e.c   = ec;
    e.z   = (ey == 4'b0000);
    e.cyc = cyc + 1 + int'(sh);
    sb.push_back(e);
    issued++;
  endtask

  // Issue one start; afterwards scramble inputs to prove they were latched.
  task automatic op(input logic [1:0] m, input logic [3:0] av, input logic [1:0] sh,
                    input logic [3:0] ey, input logic ec, input bit push);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    a     = av;
    shift = sh;
    if (push) expect_result(ey, ec, sh);
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    a     = ~av;
    shift = ~sh;
  endtask

  task automatic wait_all(input int budget);
    for (int i = 0; i < budget && done_seen < issued; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_seen < issued) check("timeout", done_seen, issued);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    a     = 4'b0000;
    shift = 2'b00;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_y", y, 4'b0000);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Directed vectors: mode, a, shift, expected y, expected carry.
    op(SRA, 4'b1000, 2'd2, 4'b1110, 1'b0, 1'b1); wait_all(20);
    op(SRL, 4'b1000, 2'd2, 4'b0010, 1'b0, 1'b1); wait_all(20);
    op(SLL, 4'b0011, 2'd3, 4'b1000, 1'b1, 1'b1); wait_all(20);
    op(ROR, 4'b1001, 2'd1, 4'b1100, 1'b1, 1'b1); wait_all(20);
    op(SRA, 4'b1111, 2'd3, 4'b1111, 1'b1, 1'b1); wait_all(20);
    // Zero shift right after a carry=1 result: carry must be cleared.
    op(SLL, 4'b1010, 2'd0, 4'b1010, 1'b0, 1'b1);
    check("busy_shift0_a", busy, 0);
    wait_all(20);
    op(ROR, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
    check("busy_shift0_b", busy, 0);
    wait_all(20);
    op(ROR, 4'b0001, 2'd3, 4'b0010, 1'b0, 1'b1); wait_all(20);
    op(SLL, 4'b1000, 2'd1, 4'b0000, 1'b1, 1'b1); wait_all(20);

    // start held high through SHIFT and DONE with changed inputs: ignored.
    @(negedge clk);
    start = 1'b1;
    mode  = SLL;
    a     = 4'b0011;
    shift = 2'd3;
    expect_result(4'b1000, 1'b1, 2'd3);
    repeat (4) begin
      @(negedge clk);
      start = 1'b1;
      mode  = SRL;
      a     = 4'b1111;
      shift = 2'd1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_all(20);
    repeat (5) @(negedge clk);
    check("hold_y", y, 4'b1000);
    check("hold_carry", carry, 1);
    check("done_count", done_seen, issued);

    // Reset in the middle of SHIFT aborts with no done pulse.
    op(SRA, 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_y", y, 4'b0000);
    check("abort_carry", carry, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_seen, issued);
    op(SRL, 4'b1011, 2'd1, 4'b0101, 1'b1, 1'b1); wait_all(20);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
